aes_key_expander: RTL
=====================

# aes_key_expander

Iterative AES key-expansion engine that generalises the accelerator's AES-128-only round-key generator to AES-128/192/256, selected per key at run time. It accepts a cipher key over a valid/ready handshake and generates one 32-bit schedule word per cycle using a single SubWord path (4 `SBox` instances). It stores the full schedule, up to 60 words, and serves any round key combinationally to the add-round-key stage by round index. It sits between the rx key shift register and the cipher datapath/controller.

## Interface
- `MAX_NK`, default 8: largest supported key length in 32-bit words.
  - Legal values: 4, 6, 8.
  - Sets the `key_in` width and the schedule storage to 4*(MAX_NK+7) words.
- `clk`  in  1  clock; all state updates on rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `key_valid`  in  1  new key offered.
- `key_ready`  out  1  engine can accept a key.
- `key_in`  in  32*MAX_NK  cipher key, left-aligned; word j = `key_in[32*MAX_NK-1-32*j -: 32]`.
- `key_len`  in  2  key length: 0 = 128-bit, 1 = 192-bit, 2 = 256-bit, 3 = illegal.
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse when the schedule is complete.
- `keys_valid`  out  1  schedule complete and readable.
- `cfg_err`  out  1  one-cycle pulse when a key with an illegal or unsupported length is accepted.
- `nr`  out  4  round count of the stored schedule (10/12/14); 0 when none.
- `rd_round`  in  4  round-key index to read.
- `rd_key`  out  128  round key `{w[4r], w[4r+1], w[4r+2], w[4r+3]}`.
- `rd_err`  out  1  read index invalid or no valid schedule.

## Operation
- Derived values: Nk = 4/6/8, Nr = Nk+6, total words Nw = 4*(Nr+1) = 44/52/60.
- States: IDLE, EXPAND, READY.
  - IDLE and READY: `key_ready`=1.
  - EXPAND: `key_ready`=0, `busy`=1.
- Accept rule: a key is accepted on a rising edge with `key_valid && key_ready`.
  - Legal length (Nk ≤ MAX_NK):
    - Latch w[0..Nk-1] from `key_in`.
    - Latch Nk and `nr`.
    - Clear `keys_valid`.
    - Set i = Nk, rcon = 0x01, phase counter p = 0.
    - Go to EXPAND.
  - `key_len`=3, or Nk > MAX_NK:
    - Pulse `cfg_err`.
    - Clear `keys_valid` and set `nr`=0.
    - Go to IDLE.
- EXPAND, one word per cycle, for i = Nk..Nw-1:
  - temp = w[i-1].
  - If p==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then advance rcon = xtime(rcon) (0x80 → 0x1b).
  - Else if Nk==8 and p==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - p wraps from Nk-1 to 0 and tracks i mod Nk; no divider is used.
  - RotWord is a left byte rotate; SubWord applies the `SBox` bytewise.
- Completion: the edge that writes w[Nw-1] moves to READY, pulses `done` and sets `keys_valid`.
- In READY a new key may be accepted; `keys_valid` drops on that same edge.
- Read port (combinational):
  - `rd_err` = !`keys_valid` || `rd_round` > `nr`.
  - If `rd_err`=1, `rd_key`=0; otherwise `rd_key` is the stored round key.
  - Reads during EXPAND return 0 with `rd_err`=1.
- Storage above w[Nw-1] is don't-care and never readable.

## Timing
- Reset values: `key_ready`=1, `busy`=0, `done`=0, `keys_valid`=0, `cfg_err`=0, `nr`=0, `rd_key`=0, `rd_err`=1; state IDLE.
- Latency:
  - Counting the accept edge as E0, the schedule completes on E(Nw-Nk): E40 for 128-bit, E46 for 192-bit, E52 for 256-bit.
  - `done` and `keys_valid` are high in the cycle that follows that edge.
- `done` and `cfg_err` are each high for exactly one cycle.
- `key_valid` while in EXPAND is ignored: no stall of the expansion, no queuing.
- `key_in`/`key_len` are sampled only on the accept edge.
- `rd_round` changes are reflected in `rd_key` in the same cycle; no registered read latency.
- `n_rst` low at any time, including mid-EXPAND, returns all outputs to their reset values immediately (asynchronous). The partial schedule is discarded.
- Back-to-back: a key accepted in the `done` cycle is legal and restarts expansion.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - `keys_valid` rises 40 cycles after accept, `nr`=10.
  - `rd_round`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `rd_round`=0 → the key itself.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - Completes in 46 cycles, `nr`=12.
  - `rd_round`=12 → e98ba06f448c773c8ecc720401002202.
  - `rd_round`=13 → `rd_err`=1, `rd_key`=0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - Completes in 52 cycles, `nr`=14.
  - `rd_round`=14 → fe4890d1e6188d0b046df344706c631e.
- Illegal length:
  - `key_len`=3 → `cfg_err` pulse, `keys_valid`=0, `nr`=0, `key_ready` stays 1.
  - With MAX_NK=4, `key_len`=2 → same response.
- Mid-operation events:
  - `key_valid` held during EXPAND → `key_ready`=0 and the schedule completes unchanged.
  - Asserting `n_rst` at cycle 20 of EXPAND → all outputs return to reset values.
  - The next 128-bit key after release expands correctly.
- Rekey from READY:
  - Accept a new 256-bit key → `keys_valid` drops on the accept edge.
  - Reads return 0 with `rd_err`=1 until the new `done`.

Source files
------------

// File: rtl/aes_key_expander.sv
// Purpose : iterative AES-128/192/256 key expansion; stores the full schedule and
//           serves any round key combinationally by round index.
// Latency : schedule complete Nw-Nk cycles after key accept (40/46/52); reads are same-cycle.
// Backpressure: key_ready low while expanding; key_valid during expansion is ignored.
//
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   key_valid/key_ready  key handshake; key_in (left-aligned, 32*MAX_NK bits), key_len (0/1/2 = 128/192/256)
//   busy, done           expansion in progress / one-cycle completion pulse
//   keys_valid, nr       stored schedule readable / its round count (0 when none)
//   cfg_err              one-cycle pulse when a key of illegal/unsupported length is accepted
//   rd_round -> rd_key   combinational round-key read; rd_err flags bad index or no schedule
module aes_key_expander #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [32*MAX_NK-1:0]  key_in,
  input  logic [1:0]            key_len,
  output logic                  busy,
  output logic                  done,
  output logic                  keys_valid,
  output logic                  cfg_err,
  output logic [3:0]            nr,
  input  logic [3:0]            rd_round,
  output logic [127:0]          rd_key,
  output logic                  rd_err
);

  localparam int         NW_MAX   = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

  state_t      r_state;
  state_t      w_state_n;

  logic [31:0] r_w [0:NW_MAX-1];
  logic [5:0]  r_i;
  logic [3:0]  r_nk;
  logic [2:0]  r_p;
  logic [7:0]  r_rcon;
  logic [3:0]  r_nr;
  logic        r_done;
  logic        r_cfg_err;
  logic        r_keys_valid;

  logic        w_accept;
  logic [3:0]  w_nk;
  logic        w_legal;
  logic [5:0]  w_nw;
  logic        w_last;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_sbox_in;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  logic [31:0] w_new;
  logic [7:0]  w_rcon_nx;
  logic [5:0]  w_rd_base;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (a^254, with 0 -> 0) followed by the affine map
  function automatic logic [7:0] f_sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = f_gmul(sq, sq);
      inv = f_gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // key_len 0/1/2/3 -> Nk 4/6/8/10; 10 is caught by the key_len==3 term
  assign w_nk     = 4'd4 + {1'b0, key_len, 1'b0};
  assign w_legal  = (key_len != 2'd3) && (w_nk <= MAX_NK_W);
  assign w_accept = key_valid && key_ready;

  assign w_nw   = {r_nr, 2'b00} + 6'd4;
  assign w_last = (r_i == w_nw - 6'd1);

  assign w_prev    = r_w[r_i - 6'd1];
  assign w_back    = r_w[r_i - {2'b00, r_nk}];
  // RotWord only on the rcon word; the Nk=8 mid-key word is SubWord without rotation
  assign w_sbox_in = (r_p == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  // single SubWord path: four byte-lane S-boxes
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign w_sub[8*b +: 8] = f_sbox(w_sbox_in[8*b +: 8]);
  end

  always_comb begin
    w_temp = w_prev;
    if (r_p == 3'd0) begin
      w_temp = w_sub ^ {r_rcon, 24'h000000};
    end else if (r_nk == 4'd8 && r_p == 3'd4) begin
      w_temp = w_sub;
    end
  end

  assign w_new     = w_back ^ w_temp;
  assign w_rcon_nx = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    key_ready = 1'b1;
    busy      = 1'b0;
    case (r_state)
      S_IDLE, S_READY: begin
        if (w_accept) w_state_n = w_legal ? S_EXPAND : S_IDLE;
      end
      S_EXPAND: begin
        key_ready = 1'b0;
        busy      = 1'b1;
        if (w_last) w_state_n = S_READY;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // control and status
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_i          <= 6'd0;
      r_nk         <= 4'd4;
      r_p          <= 3'd0;
      r_rcon       <= 8'h01;
      r_nr         <= 4'd0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (w_accept) begin
        r_keys_valid <= 1'b0;
        if (w_legal) begin
          r_nk   <= w_nk;
          r_nr   <= w_nk + 4'd6;
          r_i    <= {2'b00, w_nk};
          r_rcon <= 8'h01;
          r_p    <= 3'd0;
        end else begin
          r_cfg_err <= 1'b1;
          r_nr      <= 4'd0;
        end
      end else if (r_state == S_EXPAND) begin
        r_i <= r_i + 6'd1;
        // p tracks i mod Nk with a wrap compare instead of a divider
        r_p <= ({1'b0, r_p} == r_nk - 4'd1) ? 3'd0 : r_p + 3'd1;
        if (r_p == 3'd0) r_rcon <= w_rcon_nx;
        if (w_last) begin
          r_done       <= 1'b1;
          r_keys_valid <= 1'b1;
        end
      end
    end
  end

  // schedule storage; contents are meaningless until keys_valid, so no reset
  always_ff @(posedge clk) begin
    if (w_accept && w_legal) begin
      for (int j = 0; j < MAX_NK; j++) begin
        r_w[j] <= key_in[32*MAX_NK-1-32*j -: 32];
      end
    end else if (r_state == S_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  assign done       = r_done;
  assign cfg_err    = r_cfg_err;
  assign keys_valid = r_keys_valid;
  assign nr         = r_nr;

  // read port; a bad index is steered to word 0 so no out-of-range access is formed
  assign rd_err    = !r_keys_valid || (rd_round > r_nr);
  assign w_rd_base = rd_err ? 6'd0 : {rd_round, 2'b00};

  always_comb begin
    rd_key = '0;
    if (!rd_err) begin
      rd_key = {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
    end
  end

endmodule
